// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait.
// Build option PIPE_STALL_CNT_EN adds stall_cycles/flush_events counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rn,
  input  logic       br_taken,
  input  logic       mem_access,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_bubble,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       memwb_bubble,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic       mem_err
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MWAIT = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  localparam logic [WAIT_W-1:0] LP_MAX = MAX_WAIT[WAIT_W-1:0];

  logic [1:0]        r_state;
  logic [1:0]        w_state_nx;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nx;
  logic              r_mem_err;
  logic              w_err_nx;
  logic              w_mstall;
  logic              w_lu;
  logic              w_hold;

  assign w_mstall = mem_access & ~dmem_ready;
  assign w_lu = ex_m2reg & (ex_rn != 5'd0) &
                ((ex_rn == id_rs) | (id_uses_rt & (ex_rn == id_rt)));
  // In MWAIT only dmem_ready matters; upstream is frozen so mem_access is stale.
  assign w_hold = ((r_state == S_RUN) & w_mstall) |
                  ((r_state == S_MWAIT) & ~dmem_ready);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!Clrn) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_en      = 1'b0;
      idex_bubble  = 1'b1;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (r_state == S_ERR || r_state == 2'd3) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (w_hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (br_taken) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else if (w_lu) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_bubble  = 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wait_nx  = r_wait_cnt;
    w_err_nx   = r_mem_err;
    unique case (r_state)
      S_RUN: begin
        if (w_mstall) begin
          w_state_nx = S_MWAIT;
          w_wait_nx  = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      S_MWAIT: begin
        if (dmem_ready) begin
          w_state_nx = S_RUN;
          w_wait_nx  = '0;
        end else if (r_wait_cnt == LP_MAX) begin
          w_state_nx = S_ERR;
          w_err_nx   = 1'b1;
        end else begin
          w_wait_nx  = r_wait_cnt + 1'b1;
        end
      end
      S_ERR: w_err_nx = 1'b1;
      default: w_state_nx = S_ERR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_nx;
      r_mem_err  <= w_err_nx;
    end
  end

  assign mem_err = r_mem_err;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!pc_en && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (ifid_flush && r_flush_events != 32'hFFFF_FFFF)
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl against a cycle-count reference model.
// Build with PIPE_STALL_CNT_EN to also cover the event counters.
module tb_pipe_hazard_ctrl;
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 15;

  logic       Clk = 1'b0;
  logic       Clrn = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rn = '0;
  logic       id_uses_rt = 0, ex_m2reg = 0, br_taken = 0;
  logic       mem_access = 0, dmem_ready = 1;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic       exmem_en, memwb_en, memwb_bubble, mem_err;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .br_taken(br_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .memwb_bubble(memwb_bubble),
`ifdef PIPE_STALL_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mem_err(mem_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: consecutive stalled cycles of the pending access, and error flag.
  int          m_stalled = 0;
  bit          m_err = 0;
  logic [31:0] m_stall_cnt = 0;
  logic [31:0] m_flush_cnt = 0;

  function automatic bit hold_now();
    if (m_stalled > 0) return !dmem_ready;
    return mem_access && !dmem_ready;
  endfunction

  function automatic bit lu_now();
    return ex_m2reg && ex_rn != 0 &&
           (ex_rn == id_rs || (id_uses_rt && ex_rn == id_rt));
  endfunction

  // {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb, memwb_bubble}
  function automatic logic [7:0] exp_ctl();
    if (!Clrn)      return 8'b0010_1001;
    if (m_err)      return 8'b0000_0001;
    if (hold_now()) return 8'b0000_0011;
    if (br_taken)   return 8'b1111_1110;
    if (lu_now())   return 8'b0001_1110;
    return 8'b1101_0110;
  endfunction

  logic [7:0] last_exp;

  task automatic step(input logic rn_, input logic br, input logic ma,
                      input logic dr, input logic m2, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rn,
                      input logic urt);
    logic [7:0] e;
    bit h;
    @(negedge Clk);
    Clrn = rn_; br_taken = br; mem_access = ma; dmem_ready = dr;
    ex_m2reg = m2; id_rs = rs; id_rt = rt; ex_rn = rn; id_uses_rt = urt;
    #1;
    e = exp_ctl();
    last_exp = e;
    chk("ctl", {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                exmem_en, memwb_en, memwb_bubble}, {24'd0, e});
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall_cnt);
    chk("flush_events", flush_events, m_flush_cnt);
`endif
    h = hold_now();
    @(posedge Clk);
    if (!rn_) begin
      m_stalled = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!e[7] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e[5] && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      if (!m_err) begin
        if (h) begin
          m_stalled++;
          if (m_stalled > MAX_WAIT) begin
            m_err = 1; m_stalled = 0;
          end
        end else m_stalled = 0;
      end
    end
  endtask

  task automatic idle(input logic rn_);
    step(rn_, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  int long_left = 0;

  initial begin
    idle(0);
    idle(0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    idle(1);
    // load-use on rs, then released
    step(1, 0, 0, 1, 1, 5'd8, 5'd0, 5'd8, 0);
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_idex_bub", {31'd0, idex_bubble}, 32'd1);
    idle(1);
    chk("lu_release", {31'd0, pc_en}, 32'd1);
    step(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 0, 1, 1, 5'd1, 5'd9, 5'd9, 0);
    chk("rt_unused", {31'd0, pc_en}, 32'd1);
    step(1, 0, 0, 1, 1, 5'd1, 5'd9, 5'd9, 1);
    chk("rt_used", {31'd0, pc_en}, 32'd0);
    step(1, 1, 0, 1, 1, 5'd8, 5'd0, 5'd8, 0);
    chk("br_lu_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_lu_pc", {31'd0, pc_en}, 32'd1);
    // memory wait, then branch (counter scenario starts from reset)
    idle(0);
    repeat (3) step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("mw_exit_pc", {31'd0, pc_en}, 32'd1);
    step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    chk("mw_run_pc", {31'd0, pc_en}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("cnt_stall3", stall_cycles, 32'd3);
    chk("cnt_flush1", flush_events, 32'd1);
`endif
    // timeout
    idle(0);
    repeat (16) step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    chk("err_set", {31'd0, mem_err}, 32'd1);
    chk("err_frozen", {31'd0, memwb_en}, 32'd0);
    repeat (3) idle(1);
    chk("err_sticky", {31'd0, mem_err}, 32'd1);
    idle(0);
    idle(1);
    chk("err_clear", {31'd0, mem_err}, 32'd0);
    chk("err_run", {31'd0, pc_en}, 32'd1);
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ma, dr;
      r = ($urandom_range(0, 99) != 0);
      if (m_err && $urandom_range(0, 3) == 0) r = 0;
      if (long_left == 0 && $urandom_range(0, 39) == 0)
        long_left = $urandom_range(5, 20);
      if (long_left > 0) begin
        ma = 1; dr = 0; long_left--;
      end else begin
        ma = 1'($urandom_range(0, 1));
        dr = ($urandom_range(0, 3) != 0);
      end
      step(r, 1'($urandom_range(0, 1)), ma, dr,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
